pll_speed_sequencer: RTL

// - Runs the CPU-clock PLL reconfiguration sequence in the CLK_50M domain.
// - Samples the OSD speed select (0..4) and UART-speed flag, which arrive asynchronously from clk_sys, and debounces them.
// - On a settled change, performs four Avalon-MM writes to the PLL reconfig controller, then waits for relock.
// - Reports busy, the applied setting and a lock-timeout flag; the clk_sys-side rate table keys off cur_speed.

---
 rtl/pll_speed_sequencer_if.sv | 21 ++
 rtl/pll_speed_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_speed_sequencer_if.sv
// Avalon-MM write-only link from the speed sequencer to the PLL reconfig controller.
interface pll_speed_sequencer_if;
  logic        cfg_write;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_data;
  logic        cfg_waitrequest;

  modport master (
    output cfg_write,
    output cfg_address,
    output cfg_data,
    input  cfg_waitrequest
  );

  modport slave (
    input  cfg_write,
    input  cfg_address,
    input  cfg_data,
    output cfg_waitrequest
  );
endinterface

// File: rtl/pll_speed_sequencer.sv
// CPU-clock PLL reconfiguration sequencer (CLK_50M domain).
// Synchronizes and debounces the requested speed/UART setting, then issues the
// four reconfig writes (mode, C0, C1, start), waits for settle and relock, and
// reports busy / applied speed / sticky lock-timeout.
module pll_speed_sequencer #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter logic [31:0] UDIV_FAST     = 32'h4F4F4,
  parameter logic [31:0] UDIV_SLOW     = 32'h40909
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [2:0]                   speed_in,
  input  logic                         uspeed_in,
  input  logic                         pll_locked,
  pll_speed_sequencer_if.master        cfg,
  output logic                         busy,
  output logic [2:0]                   cur_speed,
  output logic                         lock_timeout
);

  localparam logic [7:0]  STABLE_N    = 8'(STABLE_CYCLES);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_MODE,
    W_C0,
    W_C1,
    W_START,
    SETTLE,
    WAIT_LOCK
  } state_t;

  // Two-flop synchronizer outputs
  logic [2:0] spd_m, spd_s;
  logic       usp_m, usp_s;
  logic       lck_m, lck_s;

  // Debounce: {speed, uspeed}
  logic [3:0] sample, last_sample, target;
  logic [7:0] stable_cnt, stable_inc;

  // Sequencer registers and their next values
  state_t      state, state_n;
  logic        wr, wr_n;
  logic [5:0]  addr, addr_n;
  logic [31:0] data, data_n;
  logic        busy_n;
  logic [2:0]  cur_n;
  logic        to_n;
  logic        app_usp, app_usp_n;
  logic [2:0]  snap_spd, snap_spd_n;
  logic        snap_usp, snap_usp_n;
  logic [23:0] cnt, cnt_n;

  // Per-write-state bus values
  logic        in_write;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  state_t      w_next;
  logic [31:0] c0_word;

  assign cfg.cfg_write   = wr;
  assign cfg.cfg_address = addr;
  assign cfg.cfg_data    = data;

  // Bring the async clk_sys-side requests and the PLL lock into this domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spd_m <= '0;
      spd_s <= '0;
      usp_m <= 1'b1;
      usp_s <= 1'b1;
      lck_m <= 1'b0;
      lck_s <= 1'b0;
    end else begin
      spd_m <= speed_in;
      spd_s <= spd_m;
      usp_m <= uspeed_in;
      usp_s <= usp_m;
      lck_m <= pll_locked;
      lck_s <= lck_m;
    end
  end

  // Out-of-range speeds collapse to 0 before the stability comparison
  assign sample     = {(spd_s > 3'd4) ? 3'd0 : spd_s, usp_s};
  assign stable_inc = stable_cnt + 8'd1;

  // Accept a new target once the clamped sample has repeated STABLE_CYCLES times
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_sample <= 4'b0001;
      stable_cnt  <= '0;
      target      <= 4'b0001;
    end else if (sample != last_sample) begin
      last_sample <= sample;
      stable_cnt  <= 8'd1;
      if (STABLE_N <= 8'd1) target <= sample;
    end else begin
      if (stable_cnt < STABLE_N) stable_cnt <= stable_inc;
      if (stable_inc >= STABLE_N) target <= sample;
    end
  end

  // C0 divider word for the snapshotted speed index
  always_comb begin
    unique case (snap_spd)
      3'd1:    c0_word = 32'h20504;
      3'd2:    c0_word = 32'h01e1e;
      3'd3:    c0_word = 32'h00f0f;
      3'd4:    c0_word = 32'h00808;
      default: c0_word = 32'h00505;
    endcase
  end

  // Sequencer state register and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      wr           <= 1'b0;
      addr         <= '0;
      data         <= '0;
      busy         <= 1'b0;
      cur_speed    <= '0;
      lock_timeout <= 1'b0;
      app_usp      <= 1'b1;
      snap_spd     <= '0;
      snap_usp     <= 1'b1;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      wr           <= wr_n;
      addr         <= addr_n;
      data         <= data_n;
      busy         <= busy_n;
      cur_speed    <= cur_n;
      lock_timeout <= to_n;
      app_usp      <= app_usp_n;
      snap_spd     <= snap_spd_n;
      snap_usp     <= snap_usp_n;
      cnt          <= cnt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    wr_n       = wr;
    addr_n     = addr;
    data_n     = data;
    busy_n     = busy;
    cur_n      = cur_speed;
    to_n       = lock_timeout;
    app_usp_n  = app_usp;
    snap_spd_n = snap_spd;
    snap_usp_n = snap_usp;
    cnt_n      = cnt;
    in_write   = 1'b0;
    w_addr     = '0;
    w_data     = '0;
    w_next     = state;

    unique case (state)
      IDLE: begin
        if (lck_s && (target != {cur_speed, app_usp})) begin
          snap_spd_n = target[3:1];
          snap_usp_n = target[0];
          busy_n     = 1'b1;
          to_n       = 1'b0;
          state_n    = W_MODE;
        end
      end
      W_MODE: begin
        in_write = 1'b1;
        w_addr   = 6'd0;
        w_data   = '0;
        w_next   = W_C0;
      end
      W_C0: begin
        in_write = 1'b1;
        w_addr   = 6'd5;
        w_data   = c0_word;
        w_next   = W_C1;
      end
      W_C1: begin
        in_write = 1'b1;
        w_addr   = 6'd5;
        w_data   = snap_usp ? UDIV_FAST : UDIV_SLOW;
        w_next   = W_START;
      end
      W_START: begin
        in_write = 1'b1;
        w_addr   = 6'd2;
        w_data   = '0;
        w_next   = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = WAIT_LOCK;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      WAIT_LOCK: begin
        if (lck_s) begin
          cur_n     = snap_spd;
          app_usp_n = snap_usp;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else if (cnt == LOCK_LAST) begin
          to_n    = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Each write state spends one cycle with cfg_write low, then holds the
    // write until accepted; this yields the one-cycle gap between writes.
    if (in_write) begin
      if (!wr) begin
        wr_n   = 1'b1;
        addr_n = w_addr;
        data_n = w_data;
      end else if (!cfg.cfg_waitrequest) begin
        wr_n    = 1'b0;
        state_n = w_next;
        cnt_n   = '0;
      end
    end
  end

endmodule
